// File: rtl/snitch_tcdm_split_pkg.sv
// Shared types for the split-I/O TCDM interconnect and the read-port arbiter.
// Holds request/response channel structs, AMO encoding and arbiter defaults.
package snitch_tcdm_split_pkg;

    localparam int unsigned TCDMAddrWidth = 32;
    localparam int unsigned DataWidth     = 64;
    localparam int unsigned StrbWidth     = DataWidth / 8;

    localparam int unsigned RdArbNumReq   = 4;
    localparam int unsigned RdArbMaxOutst = 4;

    typedef logic [TCDMAddrWidth-1:0]        addr_t;
    typedef logic [DataWidth-1:0]            data_t;
    typedef logic [StrbWidth-1:0]            strb_t;
    typedef logic [$clog2(RdArbNumReq)-1:0]  rd_arb_id_t;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        addr_t   addr;
        logic    write;
        amo_op_e amo;
        data_t   data;
        strb_t   strb;
    } tcdm_req_chan_t;

    typedef struct packed {
        data_t data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_req_t;

    typedef struct packed {
        logic           q_ready;
        tcdm_rsp_chan_t p;
        logic           p_valid;
    } tcdm_rsp_t;

endpackage

// File: rtl/snitch_tcdm_rd_id_fifo.sv
// In-order FIFO of requester IDs for reads in flight; synchronous active-low reset.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module snitch_tcdm_rd_id_fifo
    import snitch_tcdm_split_pkg::*;
#(
    parameter int unsigned Depth   = RdArbMaxOutst,
    parameter int unsigned IdWidth = $bits(rd_arb_id_t)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push,
    input  logic [IdWidth-1:0] push_id,
    input  logic               pop,
    output logic [IdWidth-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [IdWidth-1:0] mem [Depth];
    logic [PtrW-1:0]    wr_ptr;
    logic [PtrW-1:0]    rd_ptr;
    logic [CntW-1:0]    count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CntW'(1);
            else if (!do_push && do_pop) count <= count - CntW'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/snitch_tcdm_rd_port_arbiter.sv
// Round-robin arbiter sharing one read-only TCDM port, with grant lock, credits and ID routing.
// Optional counters enabled by defining SNITCH_TCDM_RD_ARB_STATS_EN.
module snitch_tcdm_rd_port_arbiter
    import snitch_tcdm_split_pkg::*;
#(
    parameter int unsigned NumReq    = RdArbNumReq,
    parameter int unsigned MaxOutst  = RdArbMaxOutst,
    parameter int unsigned AddrWidth = TCDMAddrWidth,
    parameter int unsigned DataWidth = snitch_tcdm_split_pkg::DataWidth
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    output logic [NumReq-1:0]           rsp_valid_o,
    output logic [DataWidth-1:0]        rsp_data_o,
    output tcdm_req_t                   tcdm_req_o,
    input  tcdm_rsp_t                   tcdm_rsp_i,
    output logic                        err_o
`ifdef SNITCH_TCDM_RD_ARB_STATS_EN
    ,
    output logic [NumReq-1:0][31:0]     grant_cnt_o,
    output logic [31:0]                 stall_cnt_o
`endif
);

    localparam int unsigned IdW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CredW = $clog2(MaxOutst + 1);

    logic [IdW-1:0]   rr_ptr;
    logic [IdW-1:0]   lock_id;
    logic             locked;
    logic [CredW-1:0] credit;
    logic [IdW-1:0]   winner;
    logic [IdW-1:0]   head_id;
    logic             any_valid;
    logic             can_issue;
    logic             q_valid;
    logic             handshake;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    // Scan downwards so the lowest offset from the rr pointer is written last and wins.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % int'(NumReq);
            if (req_valid_i[IdW'(idx)]) begin
                winner    = IdW'(idx);
                any_valid = 1'b1;
            end
        end
        if (locked) winner = lock_id;
    end

    assign pop       = tcdm_rsp_i.p_valid && !fifo_empty;
    assign can_issue = ((credit < CredW'(MaxOutst)) && !fifo_full) || pop;
    assign q_valid   = locked || (can_issue && any_valid);
    assign handshake = q_valid && tcdm_rsp_i.q_ready;

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (handshake) req_ready_o[winner] = 1'b1;
        if (pop)       rsp_valid_o[head_id] = 1'b1;
    end

    assign rsp_data_o = pop ? DataWidth'(tcdm_rsp_i.p.data) : '0;

    always_comb begin
        tcdm_req_o         = '0;
        tcdm_req_o.q.amo   = AMONone;
        tcdm_req_o.q_valid = q_valid;
        if (q_valid) begin
            tcdm_req_o.q.addr = addr_t'(req_addr_i[int'(winner)*AddrWidth +: AddrWidth]);
            tcdm_req_o.q.strb = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr  <= '0;
            lock_id <= '0;
            locked  <= 1'b0;
            credit  <= '0;
            err_o   <= 1'b0;
        end else begin
            if (handshake) begin
                locked <= 1'b0;
                rr_ptr <= (winner == IdW'(NumReq - 1)) ? '0 : winner + IdW'(1);
            end else if (q_valid) begin
                locked  <= 1'b1;
                lock_id <= winner;
            end
            if (handshake && !pop)      credit <= credit + CredW'(1);
            else if (!handshake && pop) credit <= credit - CredW'(1);
            if (tcdm_rsp_i.p_valid && fifo_empty) err_o <= 1'b1;
        end
    end

    snitch_tcdm_rd_id_fifo #(
        .Depth   (MaxOutst),
        .IdWidth (IdW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (handshake),
        .push_id (winner),
        .pop     (pop),
        .head    (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef SNITCH_TCDM_RD_ARB_STATS_EN
    logic stall;

    // A stall is either a back-pressured request or pending work blocked by credit.
    assign stall = (q_valid && !tcdm_rsp_i.q_ready) || (|req_valid_i && !q_valid);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            grant_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (handshake && grant_cnt_o[winner] != '1)
                grant_cnt_o[winner] <= grant_cnt_o[winner] + 32'd1;
            if (stall && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_snitch_tcdm_rd_port_arbiter.sv
// Bench for snitch_tcdm_rd_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_snitch_tcdm_rd_port_arbiter;
    import snitch_tcdm_split_pkg::*;

    localparam int NumReq   = 4;
    localparam int MaxOutst = 4;
    localparam int AW       = 32;
    localparam int DW       = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NumReq-1:0]    req_valid;
    logic [NumReq-1:0]    req_ready;
    logic [NumReq*AW-1:0] req_addr;
    logic [NumReq-1:0]    rsp_valid;
    logic [DW-1:0]        rsp_data;
    tcdm_req_t            tcdm_req;
    tcdm_rsp_t            tcdm_rsp;
    logic                 err;
`ifdef SNITCH_TCDM_RD_ARB_STATS_EN
    logic [NumReq-1:0][31:0] grant_cnt;
    logic [31:0]             stall_cnt;
`endif

    snitch_tcdm_rd_port_arbiter #(
        .NumReq    (NumReq),
        .MaxOutst  (MaxOutst),
        .AddrWidth (AW),
        .DataWidth (DW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .tcdm_req_o  (tcdm_req),
        .tcdm_rsp_i  (tcdm_rsp),
        .err_o       (err)
`ifdef SNITCH_TCDM_RD_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Stimulus state: requester valids/addresses, interconnect ready/response.
    logic [NumReq-1:0] rv;
    logic [AW-1:0]     ra [NumReq];
    logic              qr;
    logic              pv;
    logic [DW-1:0]     pd;
    int                mode;
    int                rel_mode;
    bit                hold;
    logic [DW-1:0]     icq [$];

    // Reference model: in-flight requester IDs in issue order, rr pointer, locked requester.
    int  inflight [$];
    int  rr_m;
    int  lock_m;
    bit  err_m;
    int  gcnt_m [NumReq];
    int  stall_m;

    logic              obs_qv;
    logic [AW-1:0]     obs_addr;
    logic [NumReq-1:0] obs_ready;
    logic [NumReq-1:0] obs_rsp;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 4095)) << 3;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        rr_m    = 0;
        lock_m  = -1;
        err_m   = 1'b0;
        stall_m = 0;
        for (int i = 0; i < NumReq; i++) gcnt_m[i] = 0;
    endtask

    task automatic do_reset(input bit keep_icq);
        rst_n = 1'b0;
        rv = '0; qr = 1'b0; pv = 1'b0; pd = '0;
        req_valid = '0;
        tcdm_rsp  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        if (!keep_icq) icq.delete();
    endtask

    // One cycle: drive inputs, check DUT against the model, advance the model.
    task automatic apply_stimulus();
        bit                pop;
        bit                can;
        bit                was_empty;
        int                win;
        bit                hs;
        logic [NumReq-1:0] e_ready;
        logic [NumReq-1:0] e_rsp;
        req_valid = rv;
        for (int i = 0; i < NumReq; i++) req_addr[i*AW +: AW] = ra[i];
        tcdm_rsp.q_ready = qr;
        tcdm_rsp.p_valid = pv;
        tcdm_rsp.p.data  = pd;
        #1;
        was_empty = (inflight.size() == 0);
        pop   = pv && !was_empty;
        e_rsp = pop ? NumReq'(1 << inflight[0]) : '0;
        can   = (inflight.size() < MaxOutst) || pop;
        win   = -1;
        if (lock_m >= 0) win = lock_m;
        else if (can) begin
            for (int k = 0; k < NumReq; k++) begin
                if (win < 0 && rv[(rr_m + k) % NumReq]) win = (rr_m + k) % NumReq;
            end
        end
        hs      = (win >= 0) && qr;
        e_ready = hs ? NumReq'(1 << win) : '0;

        obs_qv    = tcdm_req.q_valid;
        obs_addr  = tcdm_req.q.addr;
        obs_ready = req_ready;
        obs_rsp   = rsp_valid;

        check_output("q_valid", 64'(tcdm_req.q_valid), 64'(win >= 0));
        if (win >= 0) begin
            check_output("q_addr", 64'(tcdm_req.q.addr), 64'(ra[win]));
            check_output("q_attr", 64'({tcdm_req.q.write, tcdm_req.q.strb, tcdm_req.q.amo}),
                         64'({1'b0, 8'hFF, AMONone}));
        end
        check_output("req_ready", 64'(req_ready), 64'(e_ready));
        check_output("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        if (pop) check_output("rsp_data", rsp_data, pd);
        check_output("err", 64'(err), 64'(err_m));
`ifdef SNITCH_TCDM_RD_ARB_STATS_EN
        for (int i = 0; i < NumReq; i++) check_output("grant_cnt", 64'(grant_cnt[i]), 64'(gcnt_m[i]));
        check_output("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif

        if (pv && was_empty) err_m = 1'b1;
        if (pop) void'(inflight.pop_front());
        if (((win >= 0) && !qr) || ((rv != '0) && (win < 0))) stall_m++;
        if (hs) begin
            inflight.push_back(win);
            icq.push_back(mem_data(ra[win]));
            rr_m   = (win + 1) % NumReq;
            lock_m = -1;
            gcnt_m[win]++;
            if (mode == 1) ra[win] = rand_addr();
            else           rv[win] = 1'b0;
        end else if (win >= 0) begin
            lock_m = win;
        end
        if (mode == 2) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = rand_addr();
                end
            end
        end

        @(negedge clk);
        if (!hold && icq.size() > 0 && (rel_mode == 0 || $urandom_range(0, 1) == 1)) begin
            pv = 1'b1;
            pd = icq.pop_front();
        end else begin
            pv = 1'b0;
            pd = '0;
        end
    endtask

    task automatic drain();
        rv = '0; qr = 1'b1; hold = 1'b0; rel_mode = 0;
        repeat (6) apply_stimulus();
    endtask

    initial begin
        int hs_cnt;
        mode = 0; rel_mode = 0; hold = 1'b0;
        for (int i = 0; i < NumReq; i++) ra[i] = '0;
        req_addr = '0;
        @(negedge clk);
        do_reset(1'b0);

        // Reset then idle, then req0 and req2 served in order.
        check_output("rst_outputs", 64'({tcdm_req.q_valid, req_ready, rsp_valid, err}), 64'(0));
        apply_stimulus();
        rv = 4'b0101; ra[0] = 32'h100; ra[2] = 32'h200; qr = 1'b1;
        apply_stimulus();
        check_output("s1_grant0", 64'(obs_ready), 64'(4'b0001));
        apply_stimulus();
        check_output("s1_grant2", 64'(obs_ready), 64'(4'b0100));
        check_output("s1_rsp0", 64'(obs_rsp), 64'(4'b0001));
        apply_stimulus();
        check_output("s1_rsp2", 64'(obs_rsp), 64'(4'b0100));

        // All four valid, continuous ready: order 0,1,2,3,0.
        do_reset(1'b0);
        mode = 1; rv = 4'b1111; qr = 1'b1;
        for (int i = 0; i < NumReq; i++) ra[i] = rand_addr();
        apply_stimulus(); check_output("s2_g0", 64'(obs_ready), 64'(4'b0001));
        apply_stimulus(); check_output("s2_g1", 64'(obs_ready), 64'(4'b0010));
        apply_stimulus(); check_output("s2_g2", 64'(obs_ready), 64'(4'b0100));
        apply_stimulus(); check_output("s2_g3", 64'(obs_ready), 64'(4'b1000));
        apply_stimulus(); check_output("s2_g4", 64'(obs_ready), 64'(4'b0001));
`ifdef SNITCH_TCDM_RD_ARB_STATS_EN
        check_output("s2_gcnt0", 64'(grant_cnt[0]), 64'(2));
        check_output("s2_gcnt3", 64'(grant_cnt[3]), 64'(1));
`endif
        mode = 0;
        drain();

        // Lock under back-pressure: address held, no grant change.
        rv = 4'b0110; ra[1] = 32'h40; ra[2] = 32'h80; qr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus();
            check_output("s3_addr_held", 64'(obs_addr), 64'(32'h40));
            check_output("s3_no_grant", 64'(obs_ready), 64'(0));
        end
        qr = 1'b1;
        apply_stimulus(); check_output("s3_grant1", 64'(obs_ready), 64'(4'b0010));
        apply_stimulus(); check_output("s3_grant2", 64'(obs_ready), 64'(4'b0100));
        drain();

        // Credit exhaustion with responses withheld, then a pop re-enables issue.
        hold = 1'b1; mode = 1; rv = 4'b1111; qr = 1'b1; pv = 1'b0;
        hs_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            apply_stimulus();
            if (obs_ready != '0) hs_cnt++;
        end
        check_output("s4_four_grants", 64'(hs_cnt), 64'(4));
        apply_stimulus();
        check_output("s4_blocked", 64'(obs_qv), 64'(0));
        pv = 1'b1; pd = icq.pop_front();
        apply_stimulus();
        check_output("s4_resume_qv", 64'(obs_qv), 64'(1));
        check_output("s4_resume_grant", 64'(obs_ready != '0), 64'(1));
        apply_stimulus();
        check_output("s4_still_full", 64'(obs_qv), 64'(0));
        mode = 0;
        drain();

        // Response with empty FIFO sets sticky error.
        pv = 1'b1; pd = 64'hDEAD;
        apply_stimulus();
        check_output("s5_no_rsp", 64'(obs_rsp), 64'(0));
        apply_stimulus();
        check_output("s5_err", 64'(err), 64'(1));
        repeat (2) apply_stimulus();
        check_output("s5_err_sticky", 64'(err), 64'(1));

        // Reset with reads in flight and a lock held.
        hold = 1'b1; mode = 0; rv = 4'b0011; qr = 1'b1;
        ra[0] = 32'h300; ra[1] = 32'h308;
        repeat (2) apply_stimulus();
        rv = 4'b1000; ra[3] = 32'h310; qr = 1'b0;
        apply_stimulus();
        check_output("s6_locked", 64'(obs_qv), 64'(1));
        do_reset(1'b1);
        apply_stimulus();
        check_output("s6_lock_clear", 64'(obs_qv), 64'(0));
        check_output("s6_err_clear", 64'(err), 64'(0));
        hold = 1'b0; pv = 1'b1; pd = icq.pop_front();
        apply_stimulus();
        check_output("s6_stale_no_rsp", 64'(obs_rsp), 64'(0));
        apply_stimulus();
        check_output("s6_stale_err", 64'(err), 64'(1));
        do_reset(1'b0);
        hold = 1'b1; mode = 1; rv = 4'b1111; qr = 1'b1;
        hs_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            apply_stimulus();
            if (obs_ready != '0) hs_cnt++;
        end
        check_output("s6_credit_zero", 64'(hs_cnt), 64'(4));

        // Random traffic: random ready, random response release, random arrivals.
        do_reset(1'b0);
        hold = 1'b0; mode = 2; rel_mode = 1;
        for (int c = 0; c < 400; c++) begin
            qr = ($urandom_range(0, 3) != 0);
            apply_stimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
